// File: rtl/fu_completion_unit.sv
// FU completion model: captures issued RS packets into per-class slots, ages them by class
// latency, then retires them through a round-robin CDB grant with one-cycle slot-free pulses.
package fu_pkg;
  localparam int NUM_FU_ALU   = 3;
  localparam int NUM_FU_MULT  = 2;
  localparam int NUM_FU_LOAD  = 2;
  localparam int NUM_FU_STORE = 2;
  localparam int FU_IDX_W     = 2;
  localparam int PREG_W       = 6;

  typedef enum logic [1:0] {
    FU_ALU   = 2'd0,
    FU_MULT  = 2'd1,
    FU_LOAD  = 2'd2,
    FU_STORE = 2'd3
  } funit_t;

  typedef struct packed {
    logic [PREG_W-1:0] idx;
    logic              ready;
  } preg_t;

  typedef struct packed {
    funit_t            funit;
    logic [PREG_W-1:0] dest_reg;
  } rs_packet_t;
endpackage

module fu_completion_unit
  import fu_pkg::*;
#(
  parameter int ALU_LAT      = 1,
  parameter int MULT_LAT     = 4,
  parameter int LOAD_LAT     = 2,
  parameter int STORE_LAT    = 1,
  parameter int STALL_THRESH = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ready,
  input  rs_packet_t              issued_packet,
  input  logic [FU_IDX_W-1:0]     issue_fu_index,
  output logic                    issue_enable,
  output logic                    update,
  output preg_t                   ready_reg,
  output logic [NUM_FU_ALU-1:0]   free_alu,
  output logic [NUM_FU_MULT-1:0]  free_mult,
  output logic [NUM_FU_LOAD-1:0]  free_load,
  output logic [NUM_FU_STORE-1:0] free_store,
  output logic                    issue_error
);
  localparam int NUM_CDB    = NUM_FU_ALU + NUM_FU_MULT + NUM_FU_LOAD;
  localparam int NUM_SLOT   = NUM_CDB + NUM_FU_STORE;
  localparam int BASE_MULT  = NUM_FU_ALU;
  localparam int BASE_LOAD  = BASE_MULT + NUM_FU_MULT;
  localparam int BASE_STORE = NUM_CDB;
  localparam int CNT_W      = 8;
  localparam int PTR_W      = $clog2(NUM_CDB);
  localparam int DCNT_W     = $clog2(NUM_SLOT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} slot_state_t;

  slot_state_t       state_q [NUM_SLOT];
  slot_state_t       state_d [NUM_SLOT];
  logic [CNT_W-1:0]  cnt_q   [NUM_SLOT];
  logic [CNT_W-1:0]  cnt_d   [NUM_SLOT];
  logic [PREG_W-1:0] dest_q  [NUM_SLOT];
  logic [PREG_W-1:0] dest_d  [NUM_SLOT];
  logic [PTR_W-1:0]  ptr_q;
  logic [PTR_W-1:0]  ptr_d;
  logic [NUM_SLOT-1:0] capture;
  logic [NUM_SLOT-1:0] free_all;
  logic [DCNT_W-1:0] done_cnt;
  logic              in_range;
  logic              found;
  logic              err_now;
  int                tgt;
  int                gnt;
  int                cand;

  // Countdown start value: a slot spends LAT edges in EXEC before it turns DONE.
  function automatic logic [CNT_W-1:0] start_cnt(input int s);
    int lat;
    if (s < BASE_MULT)       lat = ALU_LAT;
    else if (s < BASE_LOAD)  lat = MULT_LAT;
    else if (s < BASE_STORE) lat = LOAD_LAT;
    else                     lat = STORE_LAT;
    return CNT_W'(lat - 1);
  endfunction

  always_comb begin
    in_range = 1'b0;
    tgt      = 0;
    case (issued_packet.funit)
      FU_ALU:   begin in_range = int'(issue_fu_index) < NUM_FU_ALU;   tgt = int'(issue_fu_index); end
      FU_MULT:  begin in_range = int'(issue_fu_index) < NUM_FU_MULT;  tgt = BASE_MULT + int'(issue_fu_index); end
      FU_LOAD:  begin in_range = int'(issue_fu_index) < NUM_FU_LOAD;  tgt = BASE_LOAD + int'(issue_fu_index); end
      FU_STORE: begin in_range = int'(issue_fu_index) < NUM_FU_STORE; tgt = BASE_STORE + int'(issue_fu_index); end
      default:  begin in_range = 1'b0; tgt = 0; end
    endcase
    for (int s = 0; s < NUM_SLOT; s++)
      capture[s] = ready && in_range && (tgt == s) && (state_q[s] == S_IDLE);
    err_now = ready && !(|capture);

    // Round-robin search over non-store slots starting at the rotate pointer.
    found = 1'b0;
    gnt   = 0;
    cand  = 0;
    for (int k = 0; k < NUM_CDB; k++) begin
      cand = int'(ptr_q) + k;
      if (cand >= NUM_CDB) cand = cand - NUM_CDB;
      if (!found && state_q[cand] == S_DONE) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
    ptr_d = ptr_q;
    if (found) ptr_d = (gnt + 1 >= NUM_CDB) ? '0 : PTR_W'(gnt + 1);

    free_all = '0;
    done_cnt = '0;
    for (int s = 0; s < NUM_SLOT; s++) begin
      state_d[s] = state_q[s];
      cnt_d[s]   = cnt_q[s];
      dest_d[s]  = dest_q[s];
      case (state_q[s])
        S_IDLE: if (capture[s]) begin
          state_d[s] = S_EXEC;
          cnt_d[s]   = start_cnt(s);
          dest_d[s]  = issued_packet.dest_reg;
        end
        S_EXEC: if (cnt_q[s] == '0) state_d[s] = S_DONE;
                else                cnt_d[s]   = cnt_q[s] - 1'b1;
        S_DONE: if (s >= BASE_STORE || (found && gnt == s)) begin
          state_d[s]  = S_IDLE;
          free_all[s] = 1'b1;
        end
        default: state_d[s] = S_IDLE;
      endcase
      if (state_d[s] == S_DONE) done_cnt = done_cnt + DCNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int s = 0; s < NUM_SLOT; s++) begin
        state_q[s] <= S_IDLE;
        cnt_q[s]   <= '0;
      end
      ptr_q        <= '0;
      update       <= 1'b0;
      ready_reg    <= '0;
      free_alu     <= '0;
      free_mult    <= '0;
      free_load    <= '0;
      free_store   <= '0;
      issue_error  <= 1'b0;
      issue_enable <= 1'b0;
    end else begin
      for (int s = 0; s < NUM_SLOT; s++) begin
        state_q[s] <= state_d[s];
        cnt_q[s]   <= cnt_d[s];
      end
      ptr_q        <= ptr_d;
      update       <= found;
      ready_reg    <= found ? '{idx: dest_q[gnt], ready: 1'b1} : '0;
      free_alu     <= free_all[BASE_MULT-1:0];
      free_mult    <= free_all[BASE_LOAD-1:BASE_MULT];
      free_load    <= free_all[BASE_STORE-1:BASE_LOAD];
      free_store   <= free_all[NUM_SLOT-1:BASE_STORE];
      issue_error  <= issue_error | err_now;
      issue_enable <= int'(done_cnt) < STALL_THRESH;
    end
  end

  // Packet payload is data only; validity lives in the slot state.
  always_ff @(posedge clock) begin
    for (int s = 0; s < NUM_SLOT; s++) dest_q[s] <= dest_d[s];
  end
endmodule

// File: tb/tb_fu_completion_unit.sv
// Directed bench for fu_completion_unit: latency, round-robin CDB order, store frees,
// issue errors and mid-flight reset, with hand-computed expectations per edge.
module tb_fu_completion_unit;
  import fu_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    ready = 1'b0;
  rs_packet_t              pkt   = '0;
  logic [FU_IDX_W-1:0]     idx   = '0;
  logic                    issue_enable;
  logic                    update;
  preg_t                   ready_reg;
  logic [NUM_FU_ALU-1:0]   free_alu;
  logic [NUM_FU_MULT-1:0]  free_mult;
  logic [NUM_FU_LOAD-1:0]  free_load;
  logic [NUM_FU_STORE-1:0] free_store;
  logic                    issue_error;

  int n_checks = 0;
  int n_fail   = 0;

  fu_completion_unit dut (
    .clock(clock), .reset(reset), .ready(ready), .issued_packet(pkt),
    .issue_fu_index(idx), .issue_enable(issue_enable), .update(update),
    .ready_reg(ready_reg), .free_alu(free_alu), .free_mult(free_mult),
    .free_load(free_load), .free_store(free_store), .issue_error(issue_error)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input funit_t f, input logic [FU_IDX_W-1:0] i, input logic [PREG_W-1:0] d);
    ready        = 1'b1;
    pkt.funit    = f;
    pkt.dest_reg = d;
    idx          = i;
  endtask

  task automatic do_reset();
    ready = 1'b0;
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();
  endtask

  task automatic test_reset();
    ready = 1'b0;
    reset = 1'b0;
    step();
    step();
    n_checks++;
    if ({update, ready_reg, free_alu, free_mult, free_load, free_store, issue_error} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {update, ready_reg, free_alu, free_mult, free_load, free_store, issue_error});
    end
    n_checks++;
    if (issue_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_issue_enable: got %b required 0", issue_enable);
    end
    reset = 1'b1;
    step();
    n_checks++;
    if (issue_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL release_issue_enable: got %b required 1", issue_enable);
    end
  endtask

  task automatic test_alu_latency();
    preg_t exp_rr;
    logic  exp_upd;
    do_reset();
    drive(FU_ALU, 2'd0, 6'd5);
    for (int e = 0; e <= 3; e++) begin
      step();
      ready   = 1'b0;
      exp_upd = (e == 2);
      exp_rr  = exp_upd ? '{idx: 6'd5, ready: 1'b1} : '0;
      n_checks++;
      if (update !== exp_upd || ready_reg !== exp_rr) begin
        n_fail++;
        $display("FAIL alu_latency edge %0d: update=%b tag=%h required update=%b tag=%h",
                 e, update, ready_reg, exp_upd, exp_rr);
      end
      n_checks++;
      if (free_alu !== (exp_upd ? 3'b001 : 3'b000)) begin
        n_fail++;
        $display("FAIL alu_free edge %0d: got %b required %b", e, free_alu, exp_upd ? 3'b001 : 3'b000);
      end
    end
  endtask

  task automatic test_mult_then_alu();
    preg_t      exp_rr;
    logic       exp_upd;
    logic [6:0] exp_free;
    do_reset();
    for (int e = 0; e <= 8; e++) begin
      if (e == 0)      drive(FU_MULT, 2'd0, 6'd7);
      else if (e == 4) drive(FU_ALU, 2'd0, 6'd9);
      else             ready = 1'b0;
      step();
      exp_upd  = (e == 5 || e == 6);
      exp_rr   = '0;
      exp_free = '0;
      if (e == 5) begin exp_rr = '{idx: 6'd7, ready: 1'b1}; exp_free = 7'b0001000; end
      if (e == 6) begin exp_rr = '{idx: 6'd9, ready: 1'b1}; exp_free = 7'b0000001; end
      n_checks++;
      if (update !== exp_upd || ready_reg !== exp_rr || {free_load, free_mult, free_alu} !== exp_free) begin
        n_fail++;
        $display("FAIL mult_then_alu edge %0d: update=%b tag=%h free=%b required %b %h %b",
                 e, update, ready_reg, {free_load, free_mult, free_alu}, exp_upd, exp_rr, exp_free);
      end
    end
    ready = 1'b0;
  endtask

  task automatic test_round_robin();
    funit_t     fu [7] = '{FU_MULT, FU_MULT, FU_LOAD, FU_LOAD, FU_ALU, FU_ALU, FU_ALU};
    logic [1:0] ix [7] = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1, 2'd2};
    int         slot_of_grant [7] = '{3, 4, 5, 6, 0, 1, 2};
    preg_t      exp_rr;
    logic       exp_upd;
    logic       exp_en;
    logic [6:0] exp_free;
    do_reset();
    for (int e = 0; e <= 12; e++) begin
      if (e < 7) drive(fu[e], ix[e], PREG_W'(10 + e));
      else       ready = 1'b0;
      step();
      exp_upd  = (e >= 5 && e <= 11);
      exp_rr   = '0;
      exp_free = '0;
      if (exp_upd) begin
        exp_rr   = '{idx: PREG_W'(5 + e), ready: 1'b1};
        exp_free = 7'b1 << slot_of_grant[e-5];
      end
      exp_en = (e < 4 || e >= 10);
      n_checks++;
      if (update !== exp_upd || ready_reg !== exp_rr) begin
        n_fail++;
        $display("FAIL rr_cdb edge %0d: update=%b tag=%h required update=%b tag=%h",
                 e, update, ready_reg, exp_upd, exp_rr);
      end
      n_checks++;
      if ({free_load, free_mult, free_alu} !== exp_free) begin
        n_fail++;
        $display("FAIL rr_free edge %0d: got %b required %b", e, {free_load, free_mult, free_alu}, exp_free);
      end
      n_checks++;
      if (issue_enable !== exp_en) begin
        n_fail++;
        $display("FAIL rr_issue_enable edge %0d: got %b required %b", e, issue_enable, exp_en);
      end
    end
  endtask

  task automatic test_store_concurrent();
    preg_t exp_rr;
    logic  exp_upd;
    do_reset();
    for (int e = 0; e <= 7; e++) begin
      if (e == 0)      drive(FU_MULT, 2'd0, 6'd21);
      else if (e == 3) drive(FU_STORE, 2'd0, 6'd30);
      else             ready = 1'b0;
      step();
      exp_upd = (e == 5);
      exp_rr  = exp_upd ? '{idx: 6'd21, ready: 1'b1} : '0;
      n_checks++;
      if (update !== exp_upd || ready_reg !== exp_rr) begin
        n_fail++;
        $display("FAIL store_cdb edge %0d: update=%b tag=%h required update=%b tag=%h",
                 e, update, ready_reg, exp_upd, exp_rr);
      end
      n_checks++;
      if (free_store !== (exp_upd ? 2'b01 : 2'b00) || free_mult !== (exp_upd ? 2'b01 : 2'b00)) begin
        n_fail++;
        $display("FAIL store_free edge %0d: store=%b mult=%b required %b", e, free_store, free_mult,
                 exp_upd ? 2'b01 : 2'b00);
      end
    end
  endtask

  task automatic test_busy_error();
    preg_t exp_rr;
    logic  exp_upd;
    do_reset();
    for (int e = 0; e <= 8; e++) begin
      if (e == 0)      drive(FU_MULT, 2'd1, 6'd22);
      else if (e == 1) drive(FU_MULT, 2'd1, 6'd23);
      else             ready = 1'b0;
      step();
      exp_upd = (e == 5);
      exp_rr  = exp_upd ? '{idx: 6'd22, ready: 1'b1} : '0;
      n_checks++;
      if (issue_error !== (e >= 1)) begin
        n_fail++;
        $display("FAIL busy_error edge %0d: got %b required %b", e, issue_error, e >= 1);
      end
      n_checks++;
      if (update !== exp_upd || ready_reg !== exp_rr || free_mult !== (exp_upd ? 2'b10 : 2'b00)) begin
        n_fail++;
        $display("FAIL busy_result edge %0d: update=%b tag=%h free=%b required %b %h",
                 e, update, ready_reg, free_mult, exp_upd, exp_rr);
      end
    end
  endtask

  task automatic test_range_error();
    do_reset();
    n_checks++;
    if (issue_error !== 1'b0) begin
      n_fail++;
      $display("FAIL error_cleared_by_reset: got %b required 0", issue_error);
    end
    drive(FU_ALU, 2'd3, 6'd40);
    for (int e = 0; e <= 4; e++) begin
      step();
      ready = 1'b0;
      n_checks++;
      if (issue_error !== 1'b1 || update !== 1'b0 || free_alu !== 3'b000) begin
        n_fail++;
        $display("FAIL range_error edge %0d: err=%b update=%b free_alu=%b required 1 0 000",
                 e, issue_error, update, free_alu);
      end
    end
  endtask

  task automatic test_reset_mid_exec();
    do_reset();
    drive(FU_MULT, 2'd0, 6'd24);
    step();
    drive(FU_ALU, 2'd1, 6'd25);
    step();
    ready = 1'b0;
    reset = 1'b0;
    step();
    n_checks++;
    if ({update, ready_reg, free_alu, free_mult, free_load, free_store, issue_enable} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %b required all zero",
               {update, ready_reg, free_alu, free_mult, free_load, free_store, issue_enable});
    end
    reset = 1'b1;
    for (int e = 0; e < 8; e++) begin
      step();
      n_checks++;
      if (update !== 1'b0 || ready_reg !== '0 || {free_alu, free_mult, free_load, free_store} !== '0) begin
        n_fail++;
        $display("FAIL mid_reset_quiet cycle %0d: update=%b tag=%h free=%b required none",
                 e, update, ready_reg, {free_alu, free_mult, free_load, free_store});
      end
      n_checks++;
      if (issue_enable !== 1'b1) begin
        n_fail++;
        $display("FAIL mid_reset_issue_enable cycle %0d: got %b required 1", e, issue_enable);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu_latency();
    test_mult_then_alu();
    test_round_robin();
    test_store_concurrent();
    test_busy_error();
    test_range_error();
    test_reset_mid_exec();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
